// File: rtl/dac_scheduler.sv
// ---------------------------------------------------------------------------
// dac_scheduler
//   Round-robin scheduler for a 4-channel SPI DAC. Grants one channel
//   request at a time, latches the frame fields and starts the SPI
//   serializer. It then follows tx_busy through one frame. A DAC clear
//   request preempts pending sample requests at the next idle point.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   req[3:0]  in   per-channel sample request
//   data[47:0]in   channel n sample in data[12n+11:12n]
//   ack[3:0]  out  one-cycle grant pulse to the selected channel
//   clr_req   in   DAC clear request
//   tx_start  out  one-cycle start pulse to the serializer
//   tx_busy   in   serializer busy
//   tx_cmd/tx_addr/tx_data  out  frame fields, stable for the whole frame
//   dac_clr   out  DAC clear pulse, CLR_CYCLES wide
//   err       out  sticky serializer-timeout flag
//
// Build option
//   DAC_SCHED_WDOG_EN : enables the 8-bit serializer watchdog. A wait
//   lasting 255 cycles sets err and forces a DAC clear. Without the macro,
//   err is tied low and the wait states never time out.
// ---------------------------------------------------------------------------
module dac_scheduler #(
   parameter logic [3:0]  CMD_WRITE  = 4'b0011,
   parameter int unsigned CLR_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [47:0] data,
   output logic [3:0]  ack,
   input  logic        clr_req,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic [3:0]  tx_cmd,
   output logic [3:0]  tx_addr,
   output logic [11:0] tx_data,
   output logic        dac_clr,
   output logic        err
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_START   = 3'd1;
   localparam logic [2:0] S_WAIT_HI = 3'd2;
   localparam logic [2:0] S_WAIT_LO = 3'd3;
   localparam logic [2:0] S_CLR     = 3'd4;

   localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES);

   logic [2:0]  state_r;
   logic [1:0]  last_grant_r;
   logic        pend_clr_r;
   logic [3:0]  clr_cnt_r;
   logic [3:0]  ack_r;
   logic        tx_start_r;
   logic        dac_clr_r;
   logic [3:0]  tx_cmd_r;
   logic [3:0]  tx_addr_r;
   logic [11:0] tx_data_r;

   logic [1:0]  cand_s;
   logic [1:0]  grant_chan_s;
   logic        grant_vld_s;
   logic [11:0] grant_data_s;
   logic        wdog_hit_s;

   // Round-robin pick: scan from last_grant+1 upward. Iterating downward
   // lets the nearest requesting channel overwrite farther ones.
   always_comb begin
      cand_s       = 2'b00;
      grant_vld_s  = 1'b0;
      grant_chan_s = last_grant_r;
      for (int i = 4; i >= 1; i--) begin
         cand_s = last_grant_r + 2'(i);
         if (req[cand_s]) begin
            grant_vld_s  = 1'b1;
            grant_chan_s = cand_s;
         end else begin
            grant_vld_s  = grant_vld_s;
         end
      end
   end

   // Sample mux for the selected channel
   always_comb begin
      grant_data_s = 12'h000;
      case (grant_chan_s)
         2'd0:    grant_data_s = data[11:0];
         2'd1:    grant_data_s = data[23:12];
         2'd2:    grant_data_s = data[35:24];
         2'd3:    grant_data_s = data[47:36];
         default: grant_data_s = 12'h000;
      endcase
   end

`ifdef DAC_SCHED_WDOG_EN
   logic [7:0] wdog_r;
   logic       err_r;

   // The timeout fires on the 255th consecutive wait cycle of one frame
   assign wdog_hit_s = (wdog_r == 8'd254);
   assign err        = err_r;

   // Watchdog counter: runs only while waiting on the serializer; err is sticky
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_r <= 8'd0;
         err_r  <= 1'b0;
      end else if ((state_r == S_WAIT_HI) || (state_r == S_WAIT_LO)) begin
         wdog_r <= wdog_r + 8'd1;
         if (wdog_hit_s) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
      end else begin
         wdog_r <= 8'd0;
         err_r  <= err_r;
      end
   end
`else
   assign wdog_hit_s = 1'b0;
   assign err        = 1'b0;
`endif

   // Main scheduler FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= S_IDLE;
         last_grant_r <= 2'd3;
         pend_clr_r   <= 1'b0;
         clr_cnt_r    <= 4'd0;
         ack_r        <= 4'b0000;
         tx_start_r   <= 1'b0;
         dac_clr_r    <= 1'b0;
         tx_cmd_r     <= 4'h0;
         tx_addr_r    <= 4'h0;
         tx_data_r    <= 12'h000;
      end else begin
         ack_r      <= 4'b0000;
         tx_start_r <= 1'b0;
         // Clear requests seen outside IDLE wait here until the next IDLE
         if (clr_req) begin
            pend_clr_r <= 1'b1;
         end else begin
            pend_clr_r <= pend_clr_r;
         end
         case (state_r)
            S_IDLE: begin
               if (clr_req || pend_clr_r) begin
                  state_r    <= S_CLR;
                  dac_clr_r  <= 1'b1;
                  clr_cnt_r  <= 4'd1;
                  pend_clr_r <= 1'b0;
               end else if (grant_vld_s) begin
                  ack_r        <= 4'b0001 << grant_chan_s;
                  tx_data_r    <= grant_data_s;
                  tx_addr_r    <= {2'b00, grant_chan_s};
                  tx_cmd_r     <= CMD_WRITE;
                  last_grant_r <= grant_chan_s;
                  state_r      <= S_START;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_START: begin
               tx_start_r <= 1'b1;
               state_r    <= S_WAIT_HI;
            end
            S_WAIT_HI: begin
               if (wdog_hit_s) begin
                  state_r   <= S_CLR;
                  dac_clr_r <= 1'b1;
                  clr_cnt_r <= 4'd1;
               end else if (tx_busy) begin
                  state_r <= S_WAIT_LO;
               end else begin
                  state_r <= S_WAIT_HI;
               end
            end
            S_WAIT_LO: begin
               if (wdog_hit_s) begin
                  state_r   <= S_CLR;
                  dac_clr_r <= 1'b1;
                  clr_cnt_r <= 4'd1;
               end else if (!tx_busy) begin
                  state_r <= S_IDLE;
               end else begin
                  state_r <= S_WAIT_LO;
               end
            end
            S_CLR: begin
               // clr_cnt_r counts cycles dac_clr has already been high
               if (clr_cnt_r >= CLR_LAST) begin
                  dac_clr_r <= 1'b0;
                  state_r   <= S_IDLE;
               end else begin
                  clr_cnt_r <= clr_cnt_r + 4'd1;
               end
            end
            default: begin
               state_r   <= S_IDLE;
               dac_clr_r <= 1'b0;
            end
         endcase
      end
   end

   assign ack      = ack_r;
   assign tx_start = tx_start_r;
   assign dac_clr  = dac_clr_r;
   assign tx_cmd   = tx_cmd_r;
   assign tx_addr  = tx_addr_r;
   assign tx_data  = tx_data_r;

endmodule

// File: tb/tb_dac_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dac_scheduler
//   Directed testbench for dac_scheduler in the default build (no watchdog).
//   The bench drives tx_busy like a serializer. Expected grants, frame
//   fields and clear widths are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_dac_scheduler;

   // Channel samples: ch0=555, ch1=9B2, ch2=7E1, ch3=C3A
   localparam logic [47:0] DATA_V = 48'hC3A_7E1_9B2_555;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [47:0] data;
   logic [3:0]  ack;
   logic        clr_req;
   logic        tx_start;
   logic        tx_busy;
   logic [3:0]  tx_cmd;
   logic [3:0]  tx_addr;
   logic [11:0] tx_data;
   logic        dac_clr;
   logic        err;

   int n_checks;
   int n_errors;
   int lat;

   dac_scheduler dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .data     (data),
      .ack      (ack),
      .clr_req  (clr_req),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .tx_cmd   (tx_cmd),
      .tx_addr  (tx_addr),
      .tx_data  (tx_data),
      .dac_clr  (dac_clr),
      .err      (err)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One complete frame: wait for the grant, check the start pulse and
   // fields, then hold tx_busy for busy_n cycles. With disturb set, a
   // clr_req pulse and a data change are applied mid-frame. Returns with
   // tx_busy just dropped; the FSM is still in WAIT_LO.
   task automatic run_frame(input logic [3:0] exp_ack, input logic [11:0] exp_data,
                            input int busy_n, input bit disturb, output int wait_n);
      logic [3:0] exp_addr;
      exp_addr = 4'd0;
      case (exp_ack)
         4'b0010: exp_addr = 4'd1;
         4'b0100: exp_addr = 4'd2;
         4'b1000: exp_addr = 4'd3;
         default: exp_addr = 4'd0;
      endcase
      wait_n = 0;
      do begin
         tick();
         wait_n++;
      end while ((ack == 4'b0000) && (wait_n < 20));
      check_eq("ack", 48'(ack), 48'(exp_ack));
      check_eq("start_during_ack", 48'(tx_start), 48'd0);
      tick();
      check_eq("tx_start", 48'(tx_start), 48'd1);
      check_eq("ack_after", 48'(ack), 48'd0);
      check_eq("tx_cmd", 48'(tx_cmd), 48'h3);
      check_eq("tx_addr", 48'(tx_addr), 48'(exp_addr));
      check_eq("tx_data", 48'(tx_data), 48'(exp_data));
      tx_busy = 1'b1;
      for (int i = 0; i < busy_n; i++) begin
         tick();
         check_eq("quiet_in_frame", 48'({dac_clr, tx_start, ack}), 48'd0);
         if (disturb && (i == 3)) begin
            clr_req = 1'b1;
            data    = 48'hFFF_FFF_FFF_FFF;
         end else if (disturb && (i == 4)) begin
            clr_req = 1'b0;
         end else begin
            clr_req = clr_req;
         end
      end
      check_eq("tx_data_held", 48'(tx_data), 48'(exp_data));
      check_eq("tx_addr_held", 48'(tx_addr), 48'(exp_addr));
      tx_busy = 1'b0;
      data    = DATA_V;
   endtask

   // Measure the dac_clr pulse width. Checks that no grant or start
   // appears while the clear is pending or active.
   task automatic count_clr(input int exp_width);
      int cnt;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         clr_req = 1'b0;
         check_eq("quiet_in_clr", 48'({tx_start, ack}), 48'd0);
         if (dac_clr) begin
            cnt++;
         end else if (cnt != 0) begin
            break;
         end else begin
            cnt = 0;
         end
      end
      check_eq("dac_clr_width", 48'(cnt), 48'(exp_width));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      req      = 4'b0000;
      data     = DATA_V;
      clr_req  = 1'b0;
      tx_busy  = 1'b0;

      // Reset state
      tick();
      tick();
      check_eq("rst_ack", 48'(ack), 48'd0);
      check_eq("rst_tx_start", 48'(tx_start), 48'd0);
      check_eq("rst_dac_clr", 48'(dac_clr), 48'd0);
      check_eq("rst_err", 48'(err), 48'd0);
      check_eq("rst_fields", 48'({tx_cmd, tx_addr, tx_data}), 48'd0);
      rst = 1'b0;

      // Single request on channel 0: ack on the first edge, start on the next
      req = 4'b0001;
      run_frame(4'b0001, 12'h555, 6, 1'b0, lat);
      check_eq("lat_first", 48'(lat), 48'd1);
      req = 4'b0000;
      tick();

      // All channels held: round robin 0,1,2,3,0. Each later grant needs one IDLE cycle.
      reset_dut();
      req = 4'b1111;
      run_frame(4'b0001, 12'h555, 32, 1'b0, lat);
      check_eq("rr_lat0", 48'(lat), 48'd1);
      run_frame(4'b0010, 12'h9B2, 32, 1'b0, lat);
      check_eq("rr_lat1", 48'(lat), 48'd2);
      run_frame(4'b0100, 12'h7E1, 32, 1'b0, lat);
      check_eq("rr_lat2", 48'(lat), 48'd2);
      run_frame(4'b1000, 12'hC3A, 32, 1'b0, lat);
      check_eq("rr_lat3", 48'(lat), 48'd2);
      run_frame(4'b0001, 12'h555, 32, 1'b0, lat);
      check_eq("rr_lat4", 48'(lat), 48'd2);
      tick();

      // clr_req and req in the same IDLE cycle: the clear goes first
      req     = 4'b0100;
      clr_req = 1'b1;
      count_clr(4);
      run_frame(4'b0100, 12'h7E1, 8, 1'b0, lat);
      check_eq("after_clr_lat", 48'(lat), 48'd1);

      // clr_req mid-frame: the frame completes, then the clear, then the next grant
      req = 4'b0010;
      run_frame(4'b0010, 12'h9B2, 10, 1'b1, lat);
      count_clr(4);
      run_frame(4'b0010, 12'h9B2, 4, 1'b0, lat);
      check_eq("pend_clr_lat", 48'(lat), 48'd1);

      // Reset in WAIT_LO: outputs clear immediately, stale busy ignored
      req = 4'b0001;
      lat = 0;
      do begin
         tick();
         lat++;
      end while ((ack == 4'b0000) && (lat < 20));
      check_eq("rst_setup_ack", 48'(ack), 48'b0001);
      req = 4'b0000;
      tick();
      check_eq("rst_setup_start", 48'(tx_start), 48'd1);
      tx_busy = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_eq("midrst_outputs", 48'({ack, tx_start, dac_clr, err}), 48'd0);
      check_eq("midrst_fields", 48'({tx_cmd, tx_addr, tx_data}), 48'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("stale_busy", 48'({tx_start, ack}), 48'd0);
      end
      tx_busy = 1'b0;
      req     = 4'b0010;
      run_frame(4'b0010, 12'h9B2, 4, 1'b0, lat);
      check_eq("post_rst_lat", 48'(lat), 48'd1);
      req = 4'b0000;
      tick();
      tick();
      check_eq("final_err", 48'(err), 48'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
